// File: rtl/hdr_block_lock_fsm.sv
// 64b/66b sync-header block-lock FSM: hunts, bit-slips and monitors lock.
// Optional lock-loss statistics are enabled by the HDR_LOCK_STATS_EN macro.
//
// Ports:
//   rx_clk_tb           in   receive clock, rising edge
//   rx_rst_tb           in   async active-high reset
//   serdes_rx_hdr       in   [1:0] sync header from SERDES
//   serdes_rx_hdr_valid in   qualifies serdes_rx_hdr
//   serdes_rx_bitslip   out  registered one-bit slip request
//   rx_block_lock       out  registered block-lock status
//   rx_lock_loss_count  out  [7:0] saturating lock-loss count
//                            (tied to 0 without HDR_LOCK_STATS_EN)

module hdr_block_lock_fsm #(
  parameter int LOCK_CNT            = 64,
  parameter int WINDOW              = 1024,
  parameter int INVALID_MAX         = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8
) (
  input  logic       rx_clk_tb,
  input  logic       rx_rst_tb,
  input  logic [1:0] serdes_rx_hdr,
  input  logic       serdes_rx_hdr_valid,
  output logic       serdes_rx_bitslip,
  output logic       rx_block_lock,
  output logic [7:0] rx_lock_loss_count
);

  localparam int SH_W  = $clog2(LOCK_CNT + 1);
  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int INV_W = $clog2(INVALID_MAX + 1);
  localparam int TMR_N = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                         BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int TMR_W = $clog2(TMR_N + 1);

  localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(LOCK_CNT - 1);
  localparam logic [SH_W-1:0]  SH_ONE   = SH_W'(1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [INV_W-1:0] INV_LAST = INV_W'(INVALID_MAX - 1);
  localparam logic [INV_W-1:0] INV_ONE  = INV_W'(1);
  localparam logic [TMR_W-1:0] HI_LAST  = TMR_W'(BITSLIP_HIGH_CYCLES - 1);
  localparam logic [TMR_W-1:0] LO_LAST  = TMR_W'(BITSLIP_LOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  typedef enum logic [1:0] {
    HUNT,
    SLIP_HIGH,
    SLIP_WAIT,
    LOCKED
  } state_t;

  state_t           r_state, w_nxt;
  logic [SH_W-1:0]  r_sh, w_sh;
  logic [WIN_W-1:0] r_win, w_win;
  logic [INV_W-1:0] r_inv, w_inv;
  logic [TMR_W-1:0] r_tmr, w_tmr;
  logic             r_bitslip;
  logic             r_lock;
  logic             w_hdr_ok;
`ifdef HDR_LOCK_STATS_EN
  logic             w_loss;
  logic [7:0]       r_loss_cnt;
`endif

  // 01 and 10 are the only legal sync headers
  assign w_hdr_ok = serdes_rx_hdr[1] ^ serdes_rx_hdr[0];

  always_comb begin
    w_nxt = r_state;
    w_sh  = r_sh;
    w_win = r_win;
    w_inv = r_inv;
    w_tmr = r_tmr;
`ifdef HDR_LOCK_STATS_EN
    w_loss = 1'b0;
`endif
    unique case (r_state)
      HUNT: begin
        if (serdes_rx_hdr_valid) begin
          if (!w_hdr_ok) begin
            w_sh  = '0;
            w_tmr = '0;
            w_nxt = SLIP_HIGH;
          end else if (r_sh == SH_LAST) begin
            w_sh  = '0;
            w_win = '0;
            w_inv = '0;
            w_nxt = LOCKED;
          end else begin
            w_sh = r_sh + SH_ONE;
          end
        end
      end
      // slip timers run every cycle, qualified or not
      SLIP_HIGH: begin
        if (r_tmr == HI_LAST) begin
          w_tmr = '0;
          w_nxt = SLIP_WAIT;
        end else begin
          w_tmr = r_tmr + TMR_ONE;
        end
      end
      SLIP_WAIT: begin
        if (r_tmr == LO_LAST) begin
          w_tmr = '0;
          w_sh  = '0;
          w_nxt = HUNT;
        end else begin
          w_tmr = r_tmr + TMR_ONE;
        end
      end
      LOCKED: begin
        if (serdes_rx_hdr_valid) begin
          // lock loss takes priority over window end
          if (!w_hdr_ok && r_inv == INV_LAST) begin
            w_win = '0;
            w_inv = '0;
            w_tmr = '0;
            w_nxt = SLIP_HIGH;
`ifdef HDR_LOCK_STATS_EN
            w_loss = 1'b1;
`endif
          end else if (r_win == WIN_LAST) begin
            w_win = '0;
            w_inv = '0;
          end else begin
            w_win = r_win + WIN_ONE;
            if (!w_hdr_ok) begin
              w_inv = r_inv + INV_ONE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge rx_clk_tb or posedge rx_rst_tb) begin
    if (rx_rst_tb) begin
      r_state   <= HUNT;
      r_sh      <= '0;
      r_win     <= '0;
      r_inv     <= '0;
      r_tmr     <= '0;
      r_bitslip <= 1'b0;
      r_lock    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_sh      <= w_sh;
      r_win     <= w_win;
      r_inv     <= w_inv;
      r_tmr     <= w_tmr;
      r_bitslip <= (w_nxt == SLIP_HIGH);
      r_lock    <= (w_nxt == LOCKED);
    end
  end

  assign serdes_rx_bitslip = r_bitslip;
  assign rx_block_lock     = r_lock;

`ifdef HDR_LOCK_STATS_EN
  always_ff @(posedge rx_clk_tb or posedge rx_rst_tb) begin
    if (rx_rst_tb) begin
      r_loss_cnt <= 8'd0;
    end else if (w_loss && r_loss_cnt != 8'hFF) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign rx_lock_loss_count = r_loss_cnt;
`else
  assign rx_lock_loss_count = 8'd0;
`endif

endmodule

// File: doc/hdr_block_lock_fsm.md
HDR_BLOCK_LOCK_FSM -- requirements
Module: hdr_block_lock_fsm

Interface
REQ-001 Parameter LOCK_CNT, default 64: consecutive valid sync headers required to acquire lock.
REQ-002 Parameter WINDOW, default 1024: header window length while locked.
REQ-003 Parameter INVALID_MAX, default 16: invalid headers within one window that force lock loss.
REQ-004 Parameter BITSLIP_HIGH_CYCLES, default 1: cycles serdes_rx_bitslip is held high per slip.
REQ-005 Parameter BITSLIP_LOW_CYCLES, default 8: settle cycles after a slip, during which headers are ignored.
REQ-006 rx_clk_tb  input  1  receive clock; all logic on the rising edge.
REQ-007 rx_rst_tb  input  1  reset; asynchronous, active-high.
REQ-008 serdes_rx_hdr  input  2  64b/66b sync header from the SERDES.
REQ-009 serdes_rx_hdr_valid  input  1  qualifies serdes_rx_hdr for the current cycle.
REQ-010 serdes_rx_bitslip  output  1  registered request to shift SERDES alignment by one bit.
REQ-011 rx_block_lock  output  1  registered block-lock status.
REQ-012 rx_lock_loss_count  output  8  saturating count of lock-loss events (see Configuration).

Function
REQ-013 Valid header = 2'b01 or 2'b10; invalid = 2'b00 or 2'b11; only counted when serdes_rx_hdr_valid=1.
REQ-014 States: HUNT, SLIP_HIGH, SLIP_WAIT, LOCKED; reset state HUNT.
REQ-015 HUNT: each qualified valid header increments sh_cnt; the header bringing sh_cnt to LOCK_CNT moves to LOCKED, rx_block_lock=1 on that same edge.
REQ-016 HUNT: a qualified invalid header clears sh_cnt and moves to SLIP_HIGH.
REQ-017 SLIP_HIGH: serdes_rx_bitslip=1 for exactly BITSLIP_HIGH_CYCLES cycles, then SLIP_WAIT.
REQ-018 SLIP_WAIT: serdes_rx_bitslip=0 for exactly BITSLIP_LOW_CYCLES cycles, headers ignored, then HUNT with sh_cnt=0.
REQ-019 LOCKED: win_cnt increments per qualified header; inv_cnt increments per qualified invalid header.
REQ-020 LOCKED: header bringing inv_cnt to INVALID_MAX -> rx_block_lock=0 on that edge, counters cleared, move to SLIP_HIGH, loss counter incremented.
REQ-021 LOCKED: header bringing win_cnt to WINDOW with inv_cnt below INVALID_MAX -> win_cnt and inv_cnt cleared, stay LOCKED.
REQ-022 Simultaneous window end and INVALID_MAX-th invalid header: lock loss wins.
REQ-023 serdes_rx_hdr_valid=0: no counter or state change except SLIP_HIGH/SLIP_WAIT cycle timers, which run every cycle.
REQ-024 Counter widths sized from parameters via $clog2; no wrap before terminal count.
REQ-025 rx_block_lock and serdes_rx_bitslip never both 1.

Reset
REQ-026 rx_rst_tb=1 immediately forces HUNT, all counters 0, serdes_rx_bitslip=0, rx_block_lock=0, rx_lock_loss_count=0, including mid-slip or mid-lock.
REQ-027 First header counted is the first qualified header sampled after rx_rst_tb deasserts.

Configuration
REQ-028 Macro HDR_LOCK_STATS_EN defined: rx_lock_loss_count counts lock-loss events, saturating at 255, cleared only by reset.
REQ-029 HDR_LOCK_STATS_EN undefined: loss counter logic omitted, rx_lock_loss_count tied to 8'd0; all other behaviour identical.

Verification
REQ-030 64 consecutive 2'b10 after reset -> rx_block_lock=1 on the edge sampling the 64th; bitslip never asserted.
REQ-031 63 x 2'b10 then 2'b11 -> bitslip high 1 cycle, low 8 cycles, no lock; then 64 x 2'b01 -> lock.
REQ-032 Locked, 16 x 2'b11 spread within 1024 headers -> rx_block_lock=0 on the 16th, one bitslip pulse, rx_lock_loss_count=1 (macro defined) / 0 (undefined).
REQ-033 Locked, 15 invalid per 1024-header window for 4 windows -> rx_block_lock stays 1; 1024th header also 16th invalid -> lock lost.
REQ-034 64 valid headers interleaved with serdes_rx_hdr_valid=0 gaps -> lock after 64th qualified header only.
REQ-035 rx_rst_tb asserted mid-lock and mid-SLIP_HIGH -> all outputs 0 without waiting for a clock edge.
